ntt_intt_stream_top: RTL and testbench
======================================

Name: ntt_intt_stream_top

Overview:
- Parametrised successor to the single-register NTT/INTT top wrapper.
- Adds a command sequencer that drives the ntt_intt core's load/start/read controls, and a flow-controlled, credit-based output path.
- The output path packs one or two 32-bit core words into the athos out_t-style rd1/rd2 pair and buffers them in a FIFO with valid/ready backpressure.
- Sits between the accelerator bus/register slave and the ntt_intt core.

Parameters:
- DATA_W, 32, width of core din/dout and each output lane.
- N_WORDS, 128, number of core words per polynomial load or read.
- PACK2, 1, 1 = two consecutive words per output beat (rd1 = even word, rd2 = odd word); 0 = one word per beat in rd2, with rd1 = 0 (legacy mode).
- FIFO_DEPTH, 4, output FIFO depth in beats; power of two, ≥ 2.
- RD_LAT, 1, cycles from core_read_en to valid core_dout; range 1..3.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command request.
- cmd_op  in  3  0 = LOAD_F, 1 = LOAD_I, 2 = FNTT, 3 = INTT, 4 = READ, others illegal.
- cmd_ready  out  1  high only in IDLE.
- din  in  DATA_W  load data.
- din_valid  in  1  load data valid.
- din_ready  out  1  high in LOAD.
- core_load_a_f / core_load_a_i / core_read_a / core_start_fntt / core_start_intt  out  1 each  single-cycle command pulses to the core.
- core_din  out  DATA_W  registered copy of din.
- core_din_en  out  1  registered din handshake.
- core_read_en  out  1  core read strobe.
- core_dout  in  DATA_W  core output word.
- core_gnt_valid  in  1  core grants a command pulse.
- core_done  in  1  core operation complete.
- dout_rd1, dout_rd2  out  DATA_W each  output beat lanes.
- dout_valid  out  1  output beat valid.
- dout_ready  in  1  consumer accepts the beat.
- busy  out  1  FSM not in IDLE.
- err_illegal  out  1  sticky illegal-command flag.

Behaviour:
- Reset (async assert, sync release): all outputs 0; FSM in IDLE; FIFO empty; counters 0; err_illegal 0. After reset cmd_ready = 1.
- FSM states: IDLE, ISSUE, LOAD, RUN, READ, DRAIN.
- IDLE:
  - cmd_valid & cmd_ready with a legal op → latch op, go to ISSUE.
  - Illegal op → set err_illegal (sticky until reset), stay in IDLE, no core pulse.
- ISSUE: drive the op's core pulse each cycle until core_gnt_valid = 1 (pulse deasserts the cycle after the grant). Then LOAD_F/LOAD_I → LOAD, FNTT/INTT → RUN, READ → READ.
- LOAD:
  - Each din_valid & din_ready cycle registers din onto core_din with core_din_en = 1 one cycle later, and increments wcnt.
  - When wcnt reaches N_WORDS: din_ready drops the same cycle the last word is accepted; go to IDLE.
- RUN: wait for core_done (level or pulse, sampled) → IDLE.
- READ:
  - core_read_en = 1 only when rcnt < N_WORDS AND (fifo_count + inflight_beats) < FIFO_DEPTH, where inflight counts words issued but not yet pushed.
  - core_dout is captured exactly RD_LAT cycles after each read_en, through a shift-register tag pipeline.
  - PACK2 = 1: even word held in a staging register; odd word completes the beat and pushes {rd1 = even, rd2 = odd}. N_WORDS must be even (checked by assertion).
  - PACK2 = 0: every word pushes {rd1 = 0, rd2 = word}.
  - After the last issue go to DRAIN.
- DRAIN: wait until all in-flight words are pushed → IDLE. FIFO contents may remain; the consumer drains them independently.
- FIFO behaviour:
  - dout_valid = !empty; pop on dout_valid & dout_ready.
  - Simultaneous push and pop when full is allowed: count unchanged, no data loss.
  - The credit rule guarantees no push is ever attempted when full; overflow is an assertion failure.
  - Pointers wrap modulo FIFO_DEPTH.
- Write-after-read: a new command is accepted while the FIFO is non-empty. The FIFO is not flushed by commands.
- Reset mid-operation: immediate return to IDLE, FIFO flushed, all core pulses dropped asynchronously.
- Output ordering: beats are emitted in core word order; no reordering.

Test Plan:
- Reset and LOAD_F: assert rst_n low mid-stream, then LOAD_F with N_WORDS = 128 words 0..127 → all outputs 0 during reset; exactly one core_load_a_f pulse held until the grant; 128 core_din_en cycles with core_din = 0..127; then IDLE with cmd_ready = 1.
- FNTT: issue op 2 with core_done arriving 50 cycles later → busy = 1 for the whole span; busy drops the cycle after done; cmd_ready = 0 throughout.
- READ, PACK2 = 1, dout_ready tied high: core returns word i = i → 64 beats with rd1 = 2k and rd2 = 2k+1, in order.
- READ with backpressure: dout_ready low for 40 cycles, FIFO_DEPTH = 4 → core_read_en stalls after 8 words; no overflow; all 64 beats are later delivered intact.
- PACK2 = 0 with RD_LAT = 3 → 128 beats with rd1 = 0 and rd2 = i, with correct latency alignment.
- Illegal op 7 → err_illegal = 1 stays sticky; no core pulse issued; a following legal command is accepted normally.

Source files
------------

// File: rtl/ntt_intt_stream_top.sv
// Command sequencer and credit-based packed output path sitting between the bus
// slave and the ntt_intt core. Words read from the core are packed into rd1/rd2 beats.
module ntt_intt_stream_top #(
  parameter int DATA_W     = 32,
  parameter int N_WORDS    = 128,
  parameter int PACK2      = 1,
  parameter int FIFO_DEPTH = 4,
  parameter int RD_LAT     = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  input  logic [2:0]        cmd_op,
  output logic              cmd_ready,
  input  logic [DATA_W-1:0] din,
  input  logic              din_valid,
  output logic              din_ready,
  output logic              core_load_a_f,
  output logic              core_load_a_i,
  output logic              core_read_a,
  output logic              core_start_fntt,
  output logic              core_start_intt,
  output logic [DATA_W-1:0] core_din,
  output logic              core_din_en,
  output logic              core_read_en,
  input  logic [DATA_W-1:0] core_dout,
  input  logic              core_gnt_valid,
  input  logic              core_done,
  output logic [DATA_W-1:0] dout_rd1,
  output logic [DATA_W-1:0] dout_rd2,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic              busy,
  output logic              err_illegal
);
  localparam int CW  = $clog2(N_WORDS + 1);
  localparam int AW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int PW  = $clog2(2 * FIFO_DEPTH + 2) + 1;
  localparam int WPB = (PACK2 != 0) ? 2 : 1;

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_LOAD, S_RUN, S_READ, S_DRAIN} state_t;

  state_t                state_q, state_d;
  logic [2:0]            op_q;
  logic [CW-1:0]         wcnt_q, wcnt_d, rcnt_q, rcnt_d;
  logic                  err_q, init_q;
  logic [DATA_W-1:0]     core_din_q;
  logic                  din_en_q;
  logic [RD_LAT-1:0]     pipe_q;
  logic [PW-1:0]         pend_q, pend_d, pend_p1, beats_after, credit_sum;
  logic                  phase_q;
  logic [DATA_W-1:0]     stage_q;
  logic [2*DATA_W-1:0]   mem_q [FIFO_DEPTH];
  logic [AW-1:0]         wptr_q, rptr_q;
  logic [AW:0]           fcnt_q;
  logic                  accept, legal, din_fire, credit_ok, cap, push, pop, empty, full;
  logic [2*DATA_W-1:0]   push_data;

  assign cmd_ready = init_q && (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign legal     = (cmd_op <= 3'd4);
  assign accept    = cmd_valid && cmd_ready;
  assign din_ready = (state_q == S_LOAD);
  assign din_fire  = din_valid && din_ready;

  // Pulses are decoded from state so an async reset removes them immediately.
  assign core_load_a_f   = (state_q == S_ISSUE) && (op_q == 3'd0);
  assign core_load_a_i   = (state_q == S_ISSUE) && (op_q == 3'd1);
  assign core_start_fntt = (state_q == S_ISSUE) && (op_q == 3'd2);
  assign core_start_intt = (state_q == S_ISSUE) && (op_q == 3'd3);
  assign core_read_a     = (state_q == S_ISSUE) && (op_q == 3'd4);
  assign core_din        = core_din_q;
  assign core_din_en     = din_en_q;
  assign err_illegal     = err_q;

  // Credit: beats the FIFO would have to hold if one more word were issued now.
  assign pend_p1      = pend_q + PW'(1);
  assign beats_after  = (PACK2 != 0) ? ((pend_p1 + PW'(1)) >> 1) : pend_p1;
  assign credit_sum   = PW'(fcnt_q) + beats_after;
  assign credit_ok    = (credit_sum <= PW'(FIFO_DEPTH));
  assign core_read_en = (state_q == S_READ) && (rcnt_q < CW'(N_WORDS)) && credit_ok;

  assign cap       = pipe_q[RD_LAT-1];
  assign push      = cap && ((PACK2 == 0) || phase_q);
  assign push_data = (PACK2 != 0) ? {stage_q, core_dout} : {{DATA_W{1'b0}}, core_dout};
  assign pend_d    = pend_q + PW'(core_read_en) - (push ? PW'(WPB) : PW'(0));

  assign empty      = (fcnt_q == '0);
  assign full       = (fcnt_q == (AW+1)'(FIFO_DEPTH));
  assign pop        = !empty && dout_ready;
  assign dout_valid = !empty;
  assign dout_rd1   = empty ? '0 : mem_q[rptr_q][2*DATA_W-1:DATA_W];
  assign dout_rd2   = empty ? '0 : mem_q[rptr_q][DATA_W-1:0];

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    rcnt_d  = rcnt_q;
    case (state_q)
      S_IDLE:  if (accept && legal) state_d = S_ISSUE;
      S_ISSUE: if (core_gnt_valid) begin
        case (op_q)
          3'd0, 3'd1: state_d = S_LOAD;
          3'd2, 3'd3: state_d = S_RUN;
          default:    state_d = S_READ;
        endcase
      end
      S_LOAD: if (din_fire) begin
        if (wcnt_q == CW'(N_WORDS - 1)) begin
          wcnt_d  = '0;
          state_d = S_IDLE;
        end else begin
          wcnt_d = wcnt_q + CW'(1);
        end
      end
      S_RUN:  if (core_done) state_d = S_IDLE;
      S_READ: if (core_read_en) begin
        if (rcnt_q == CW'(N_WORDS - 1)) begin
          rcnt_d  = '0;
          state_d = S_DRAIN;
        end else begin
          rcnt_d = rcnt_q + CW'(1);
        end
      end
      S_DRAIN: if (pend_q == '0) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      op_q       <= '0;
      wcnt_q     <= '0;
      rcnt_q     <= '0;
      err_q      <= 1'b0;
      init_q     <= 1'b0;
      core_din_q <= '0;
      din_en_q   <= 1'b0;
      pipe_q     <= '0;
      pend_q     <= '0;
      phase_q    <= 1'b0;
      stage_q    <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      fcnt_q     <= '0;
    end else begin
      state_q  <= state_d;
      wcnt_q   <= wcnt_d;
      rcnt_q   <= rcnt_d;
      init_q   <= 1'b1;
      din_en_q <= din_fire;
      pend_q   <= pend_d;
      if (accept && legal)  op_q <= cmd_op;
      if (accept && !legal) err_q <= 1'b1;
      if (din_fire)         core_din_q <= din;
      pipe_q[0] <= core_read_en;
      for (int i = 1; i < RD_LAT; i++) pipe_q[i] <= pipe_q[i-1];
      if (cap) begin
        phase_q <= !phase_q;
        if (!phase_q) stage_q <= core_dout;
      end
      if (push) wptr_q <= wptr_q + AW'(1);
      if (pop)  rptr_q <= rptr_q + AW'(1);
      fcnt_q <= fcnt_q + (AW+1)'(push) - (AW+1)'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= push_data;
  end

  a_even_words: assert property (@(posedge clk) disable iff (!rst_n)
    !((PACK2 != 0) && ((N_WORDS % 2) != 0)));
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && full && !pop));
endmodule

// File: tb/tb_ntt_intt_stream_top.sv
// Bench for ntt_intt_stream_top: two instances (packed RD_LAT=1, legacy RD_LAT=3)
// share the command/data stimulus; each has its own small core model and scoreboard.
module tb_ntt_intt_stream_top;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic [2:0]  cmd_op = '0;
  logic [31:0] din = '0;
  logic        din_valid = 1'b0;
  logic        core_done = 1'b0;
  logic        dout_ready = 1'b0;

  logic        cmd_ready0, din_ready0, lf0, li0, ra0, sf0, si0, cden0, ren0, gnt0, dv0, busy0, err0;
  logic [31:0] cdin0, cdout0, rd1_0, rd2_0;
  logic        cmd_ready1, din_ready1, lf1, li1, ra1, sf1, si1, cden1, ren1, gnt1, dv1, busy1, err1;
  logic [31:0] cdin1, cdout1, rd1_1, rd2_1;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  ntt_intt_stream_top u0 (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_ready(cmd_ready0),
    .din(din), .din_valid(din_valid), .din_ready(din_ready0),
    .core_load_a_f(lf0), .core_load_a_i(li0), .core_read_a(ra0),
    .core_start_fntt(sf0), .core_start_intt(si0), .core_din(cdin0), .core_din_en(cden0),
    .core_read_en(ren0), .core_dout(cdout0), .core_gnt_valid(gnt0), .core_done(core_done),
    .dout_rd1(rd1_0), .dout_rd2(rd2_0), .dout_valid(dv0), .dout_ready(dout_ready),
    .busy(busy0), .err_illegal(err0));

  ntt_intt_stream_top #(.PACK2(0), .RD_LAT(3)) u1 (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_ready(cmd_ready1),
    .din(din), .din_valid(din_valid), .din_ready(din_ready1),
    .core_load_a_f(lf1), .core_load_a_i(li1), .core_read_a(ra1),
    .core_start_fntt(sf1), .core_start_intt(si1), .core_din(cdin1), .core_din_en(cden1),
    .core_read_en(ren1), .core_dout(cdout1), .core_gnt_valid(gnt1), .core_done(core_done),
    .dout_rd1(rd1_1), .dout_rd2(rd2_1), .dout_valid(dv1), .dout_ready(dout_ready),
    .busy(busy1), .err_illegal(err1));

  // Core models: grant one cycle after a pulse appears; word i of a read returns value i,
  // visible exactly RD_LAT cycles after its read strobe and garbage otherwise.
  logic        gq0, gq1;
  logic [31:0] ridx0, ridx1, dq0, dq1 [3];
  assign gnt0   = gq0;
  assign gnt1   = gq1;
  assign cdout0 = dq0;
  assign cdout1 = dq1[2];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gq0 <= 1'b0; gq1 <= 1'b0; ridx0 <= '0; ridx1 <= '0;
      dq0 <= 32'hDEAD_BEEF; dq1[0] <= 32'hDEAD_BEEF; dq1[1] <= 32'hDEAD_BEEF; dq1[2] <= 32'hDEAD_BEEF;
    end else begin
      gq0 <= (lf0 | li0 | ra0 | sf0 | si0) & ~gq0;
      gq1 <= (lf1 | li1 | ra1 | sf1 | si1) & ~gq1;
      if (ra0) ridx0 <= '0; else if (ren0) ridx0 <= ridx0 + 1;
      if (ra1) ridx1 <= '0; else if (ren1) ridx1 <= ridx1 + 1;
      dq0    <= ren0 ? ridx0 : 32'hDEAD_BEEF;
      dq1[0] <= ren1 ? ridx1 : 32'hDEAD_BEEF;
      dq1[1] <= dq1[0];
      dq1[2] <= dq1[1];
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboards and monitors.
  logic [63:0] exp_q0[$];
  logic [63:0] exp_q1[$];
  logic [63:0] last0, last1, e;
  int beats0, beats1, ld_exp0, ld_exp1, ld_cnt0, ld_cnt1, ren_cnt0, ren_cnt1;
  int eps0, eps1, lf_cyc0;
  logic [31:0] last_din0;
  logic p_prev0 = 1'b0, p_prev1 = 1'b0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (dv0 && dout_ready) begin
        if (exp_q0.size() == 0) chk("u0_unexpected_beat", {rd1_0, rd2_0}, 64'hX);
        else begin e = exp_q0.pop_front(); chk("u0_beat", {rd1_0, rd2_0}, e); end
        last0 = {rd1_0, rd2_0}; beats0++;
      end
      if (dv1 && dout_ready) begin
        if (exp_q1.size() == 0) chk("u1_unexpected_beat", {rd1_1, rd2_1}, 64'hX);
        else begin e = exp_q1.pop_front(); chk("u1_beat", {rd1_1, rd2_1}, e); end
        last1 = {rd1_1, rd2_1}; beats1++;
      end
      if (cden0) begin chk("u0_core_din", 64'(cdin0), 64'(ld_exp0)); ld_exp0++; ld_cnt0++; last_din0 = cdin0; end
      if (cden1) begin chk("u1_core_din", 64'(cdin1), 64'(ld_exp1)); ld_exp1++; ld_cnt1++; end
      if (ren0) ren_cnt0++;
      if (ren1) ren_cnt1++;
      if (lf0) lf_cyc0++;
      if ((lf0 | li0 | ra0 | sf0 | si0) && !p_prev0) eps0++;
      if ((lf1 | li1 | ra1 | sf1 | si1) && !p_prev1) eps1++;
    end
    p_prev0 = lf0 | li0 | ra0 | sf0 | si0;
    p_prev1 = lf1 | li1 | ra1 | sf1 | si1;
  end

  task automatic clear_mon();
    ld_exp0 = 0; ld_exp1 = 0; ld_cnt0 = 0; ld_cnt1 = 0; ren_cnt0 = 0; ren_cnt1 = 0;
    eps0 = 0; eps1 = 0; lf_cyc0 = 0; beats0 = 0; beats1 = 0;
  endtask

  task automatic do_cmd(input logic [2:0] op);
    int t = 0;
    @(negedge clk);
    while (!(cmd_ready0 && cmd_ready1) && t < 3000) begin @(negedge clk); t++; end
    chk("cmd_ready_wait_ok", 64'(t < 3000), 64'd1);
    cmd_valid = 1'b1; cmd_op = op;
    @(posedge clk); #1;
    cmd_valid = 1'b0; cmd_op = '0;
  endtask

  task automatic wait_idle(input string name);
    int t = 0;
    @(negedge clk);
    while ((busy0 || busy1 || exp_q0.size() != 0 || exp_q1.size() != 0) && t < 5000) begin
      @(negedge clk); t++;
    end
    chk(name, 64'(t < 5000), 64'd1);
  endtask

  task automatic check_rst_outs(input string name);
    chk(name, {cmd_ready0, din_ready0, lf0, li0, ra0, sf0, si0, |cdin0, cden0, ren0, |rd1_0, |rd2_0,
               dv0, busy0, err0, cmd_ready1, din_ready1, lf1, li1, ra1, sf1, si1, |cdin1, cden1,
               ren1, |rd1_1, |rd2_1, dv1, busy1, err1}, 64'd0);
  endtask

  task automatic gen_read_exp();
    for (int k = 0; k < 64; k++) exp_q0.push_back({32'(2 * k), 32'(2 * k + 1)});
    for (int i = 0; i < 128; i++) exp_q1.push_back({32'd0, 32'(i)});
  endtask

  initial begin
    clear_mon();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_rst_outs("outputs_in_reset");
    rst_n = 1'b1;
    @(negedge clk);
    chk("cmd_ready_after_reset", {cmd_ready0, cmd_ready1}, 64'd3);

    // Abort a read that has filled the FIFO; reset must flush it.
    do_cmd(3'd4);
    repeat (12) @(negedge clk);
    chk("fifo_filled_before_abort", {dv0, dv1}, 64'd3);
    rst_n = 1'b0;
    #1;
    check_rst_outs("outputs_after_async_reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1; dout_ready = 1'b1;
    repeat (5) @(negedge clk);
    chk("fifo_flushed", {dv0, dv1}, 64'd0);

    // LOAD_F of words 0..127; extra din_valid beyond the last word must be ignored.
    clear_mon();
    do_cmd(3'd0);
    for (int i = 0; i < 128; i++) begin
      int t = 0;
      din = 32'(i); din_valid = 1'b1;
      @(negedge clk);
      while (!din_ready0 && t < 100) begin @(negedge clk); t++; end
      @(posedge clk); #1;
    end
    din = 32'd999;
    repeat (3) @(negedge clk);
    chk("din_ready_dropped", {din_ready0, din_ready1}, 64'd0);
    din_valid = 1'b0; din = '0;
    wait_idle("load_idle");
    chk("load_words_u0", 64'(ld_cnt0), 64'd128);
    chk("load_words_u1", 64'(ld_cnt1), 64'd128);
    chk("load_last_word", 64'(last_din0), 64'd127);
    chk("load_pulse_episodes", 64'(eps0), 64'd1);
    chk("load_pulse_cycles", 64'(lf_cyc0), 64'd2);
    chk("cmd_ready_after_load", {cmd_ready0, cmd_ready1}, 64'd3);

    // FNTT with done 50 cycles after the command.
    do_cmd(3'd2);
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      chk("fntt_busy", {busy0, busy1, cmd_ready0, cmd_ready1}, 64'b1100);
    end
    @(posedge clk); #1 core_done = 1'b1;
    @(posedge clk); #1 core_done = 1'b0;
    @(negedge clk);
    chk("fntt_busy_drop", {busy0, busy1, cmd_ready0, cmd_ready1}, 64'b0011);

    // READ with the consumer always ready.
    clear_mon();
    gen_read_exp();
    do_cmd(3'd4);
    wait_idle("read_free_done");
    chk("read_beats_u0", 64'(beats0), 64'd64);
    chk("read_beats_u1", 64'(beats1), 64'd128);
    chk("read_last_u0", last0, 64'h0000_007E_0000_007F);
    chk("read_last_u1", last1, 64'h0000_0000_0000_007F);

    // READ with 40 cycles of backpressure: credit limits issue to a full FIFO.
    clear_mon();
    dout_ready = 1'b0;
    gen_read_exp();
    do_cmd(3'd4);
    repeat (40) @(negedge clk);
    chk("bp_reads_u0", 64'(ren_cnt0), 64'd8);
    chk("bp_reads_u1", 64'(ren_cnt1), 64'd4);
    chk("bp_fifo_valid", {dv0, dv1}, 64'd3);
    chk("bp_beat_head_u0", {rd1_0, rd2_0}, 64'h0000_0000_0000_0001);
    dout_ready = 1'b1;
    wait_idle("read_bp_done");
    chk("bp_beats_u0", 64'(beats0), 64'd64);
    chk("bp_beats_u1", 64'(beats1), 64'd128);

    // Illegal op 7: sticky error, no pulse; a later INTT still runs.
    clear_mon();
    do_cmd(3'd7);
    repeat (3) @(negedge clk);
    chk("illegal_err", {err0, err1, busy0, busy1}, 64'b1100);
    chk("illegal_no_pulse", 64'(eps0 + eps1), 64'd0);
    do_cmd(3'd3);
    repeat (5) @(negedge clk);
    chk("intt_busy", {busy0, busy1}, 64'd3);
    @(posedge clk); #1 core_done = 1'b1;
    @(posedge clk); #1 core_done = 1'b0;
    wait_idle("intt_done");
    chk("intt_pulses", {32'(eps0), 32'(eps1)}, {32'd1, 32'd1});
    chk("err_sticky", {err0, err1}, 64'd3);
    chk("queues_empty", 64'(exp_q0.size() + exp_q1.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
